// File: rtl/alu_acc8_if.sv
// Operand/result bundle for the alu_acc8 execution unit.
// Master drives operands and opcode; slave returns the result.
interface alu_acc8_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] ALU_Out;

  modport master (
    output A,
    output B,
    output opcode,
    input  ALU_Out
  );

  modport slave (
    input  A,
    input  B,
    input  opcode,
    output ALU_Out
  );
endinterface

// File: rtl/alu_acc8.sv
// Registered 16-op ALU with an internal accumulator.
// One-cycle latency; opcodes 4-6 also update acc.
module alu_acc8 #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_acc8_if.slave  bus
);
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] alu_out_q;
  logic [WIDTH-1:0] alu_out_d;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] prod;

  assign a = bus.A;
  assign b = bus.B;
  assign prod = a * b;
  assign bus.ALU_Out = alu_out_q;

  always_comb begin
    acc_d     = acc;
    alu_out_d = '0;
    unique case (bus.opcode)
      4'h0: alu_out_d = a + b;
      4'h1: alu_out_d = a - b;
      4'h2: alu_out_d = prod;
      4'h3: alu_out_d = (b == '0) ? '1 : a / b;
      4'h4: begin
        acc_d     = acc + a;
        alu_out_d = acc_d;
      end
      4'h5: begin
        acc_d     = acc * a;
        alu_out_d = acc_d;
      end
      4'h6: begin
        acc_d     = acc + prod;
        alu_out_d = acc_d;
      end
      4'h7: alu_out_d = {a[WIDTH-2:0], a[WIDTH-1]};
      4'h8: alu_out_d = {a[0], a[WIDTH-1:1]};
      4'h9: alu_out_d = a & b;
      4'hA: alu_out_d = a | b;
      4'hB: alu_out_d = a ^ b;
      4'hC: alu_out_d = ~(a & b);
      // Compares yield a zero-extended single-bit truth value
      4'hD: alu_out_d = {{(WIDTH-1){1'b0}}, a == b};
      4'hE: alu_out_d = {{(WIDTH-1){1'b0}}, a > b};
      4'hF: alu_out_d = {{(WIDTH-1){1'b0}}, a < b};
      default: alu_out_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      alu_out_q <= '0;
    end else begin
      acc       <= acc_d;
      alu_out_q <= alu_out_d;
    end
  end
endmodule

// File: tb/tb_alu_acc8.sv
// Scoreboard bench for alu_acc8: directed cases plus
// random traffic against an arithmetic reference model.
module tb_alu_acc8;
  logic clk;
  logic rst;

  alu_acc8_if #(.WIDTH(8)) bus ();

  alu_acc8 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int out;
    int acc;
    int op;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   m_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_out(
    input int op, input int a, input int b,
    inout int acc
  );
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return (a * b) % 256;
      3: return (b == 0) ? 255 : a / b;
      4: begin acc = (acc + a) % 256; return acc; end
      5: begin acc = (acc * a) % 256; return acc; end
      6: begin acc = (acc + a * b) % 256; return acc; end
      7: return (a * 2) % 256 + a / 128;
      8: return a / 2 + (a % 2) * 128;
      9: return a & b;
      10: return a | b;
      11: return a ^ b;
      12: return 255 - (a & b);
      13: return (a == b) ? 1 : 0;
      14: return (a > b) ? 1 : 0;
      default: return (a < b) ? 1 : 0;
    endcase
  endfunction

  task automatic step(
    input bit r, input int op,
    input int a, input int b
  );
    exp_t e;
    @(negedge clk);
    rst        = r;
    bus.opcode = op[3:0];
    bus.A      = a[7:0];
    bus.B      = b[7:0];
    if (r) begin
      m_acc = 0;
      e.out = 0;
    end else begin
      e.out = ref_out(op, a, b, m_acc);
    end
    e.acc = m_acc;
    e.op  = r ? -1 : op;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (bus.ALU_Out !== e.out[7:0]) begin
        errors++;
        $display("FAIL alu_out op=%0d got %02h want %02h",
                 e.op, bus.ALU_Out, e.out[7:0]);
      end
      checks++;
      if (dut.acc !== e.acc[7:0]) begin
        errors++;
        $display("FAIL acc op=%0d got %02h want %02h",
                 e.op, dut.acc, e.acc[7:0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    m_acc  = 0;
    rst        = 1'b1;
    bus.opcode = '0;
    bus.A      = '0;
    bus.B      = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 8'h0A, 8'h05);
    step(0, 1, 8'h00, 8'h01);
    step(0, 2, 8, 2);
    step(0, 3, 8'h08, 8'h08);
    step(0, 3, 8'h08, 8'h00);
    step(1, 0, 0, 0);
    step(0, 6, 8, 1);
    step(0, 6, 8, 1);
    step(0, 4, 8'h10, 0);
    step(0, 5, 8'h04, 0);
    step(0, 7, 8'hB1, 0);
    step(0, 7, 8'h80, 0);
    step(0, 8, 8'h01, 0);
    step(0, 12, 8'hAA, 8'h55);
    step(0, 9, 8'hAA, 8'h0A);
    step(0, 13, 9, 9);
    step(0, 14, 8'hAA, 8'h55);
    step(0, 14, 8'h0A, 8'h55);
    step(0, 15, 8'h0A, 8'h55);
    step(0, 15, 8'h55, 8'h55);
    step(0, 6, 8'h13, 8'h07);
    step(0, 6, 8'h21, 8'h05);
    step(1, 6, 8'h21, 8'h05);
    step(0, 6, 2, 3);
    step(0, 4, 10, 0);
    step(0, 4, 10, 0);
    step(0, 4, 10, 0);
    for (int i = 0; i < 400; i++) begin
      int op;
      int a;
      int b;
      op = $urandom_range(0, 15);
      a  = $urandom_range(0, 255);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) b = a;
      step($urandom_range(0, 49) == 0, op, a, b);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
